load_store_unit: RTL and testbench

- Sits directly downstream of the single-cycle datapath's ALU and regfile read ports.
- Turns a load/store request (effective address, rs2 data, funct3) into a word-aligned bus transaction with byte enables.
- Holds the datapath with a stall while the bus is busy.
- Returns a sign- or zero-extended load result for the regfile write-back mux, replacing the zero-latency data memory with a variable-latency bus.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath load/store requests into word-aligned bus transactions.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 err_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [3:0]           bus_be_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic                 bus_gnt_i,
  input  logic                 bus_rvalid_i,
  input  logic [DataWidth-1:0] bus_rdata_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state, state_next;
  logic                   we_q;
  logic [2:0]             funct3_q;
  logic [1:0]             off_q;
  logic [AddrWidth-3:0]   word_q;
  logic [3:0]             be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth-1:0]   rd_data_q;
  logic                   err_q;
  logic [CntW-1:0]        cnt_q;
  logic                   misalign;
  logic                   reject;
  logic [DataWidth-1:0]   load_result;

  function automatic logic funct3_invalid(input logic we, input logic [2:0] f3);
    if (we) return f3 > 3'b010;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject      = funct3_invalid(we_i, funct3_i) || misalign;
  assign load_result = we_q ? '0 : extend_load(funct3_q, off_q, bus_rdata_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_i) state_next = reject ? DONE : REQ;
      REQ:     if (bus_gnt_i) state_next = bus_rvalid_i ? DONE : WAIT;
      WAIT:    if (bus_rvalid_i || (cnt_q == CntLast)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, response capture and WAIT timeout counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_q      <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      word_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          we_q      <= we_i;
          funct3_q  <= funct3_i;
          off_q     <= addr_i[1:0];
          word_q    <= addr_i[AddrWidth-1:2];
          be_q      <= byte_enables(funct3_i, addr_i[1:0]);
          wdata_q   <= lane_replicate(funct3_i, wr_data_i);
          rd_data_q <= '0;
          err_q     <= reject;
          cnt_q     <= '0;
        end
        REQ: if (bus_gnt_i && bus_rvalid_i) rd_data_q <= load_result;
        WAIT: begin
          if (bus_rvalid_i) begin
            rd_data_q <= load_result;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Timed-out accesses keep the zero loaded into rd_data_q at accept
            if (cnt_q == CntLast) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o     = ((state == IDLE) && req_i) || (state == REQ) || (state == WAIT);
  assign done_o      = (state == DONE);
  assign bus_req_o   = (state == REQ);
  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {word_q, 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit (TimeoutCycles = 4) with a bus responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        stall_o, done_o, err_o, bus_req_o, bus_we_o;
  logic [31:0] rd_data_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wr_data_i(wr_data_i), .stall_o(stall_o), .done_o(done_o),
    .rd_data_o(rd_data_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    bit          e_err;
    int          e_done;
    int          e_req;
  } vec_t;

  vec_t vecs[$];
  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t mk(input bit we, input logic [2:0] f3,
                              input logic [31:0] addr, wdata, rdata,
                              input int gd, rv,
                              input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ew, er,
                              input bit ee, input int ed, eq);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_dly = gd; v.rv_dly = rv; v.e_addr = ea; v.e_be = eb; v.e_wdata = ew;
    v.e_rd = er; v.e_err = ee; v.e_done = ed; v.e_req = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"},   {31'b0, stall_o},   32'h0);
    check({tag, " done"},    {31'b0, done_o},    32'h0);
    check({tag, " err"},     {31'b0, err_o},     32'h0);
    check({tag, " rd_data"}, rd_data_o,          32'h0);
    check({tag, " bus_req"}, {31'b0, bus_req_o}, 32'h0);
    check({tag, " bus_we"},  {31'b0, bus_we_o},  32'h0);
    check({tag, " bus_addr"}, bus_addr_o,        32'h0);
    check({tag, " bus_be"},  {28'b0, bus_be_o},  32'h0);
    check({tag, " bus_wdata"}, bus_wdata_o,      32'h0);
  endtask

  // Drives one request, acts as the bus slave, and checks the transaction end to end.
  task automatic run_vec(input int idx, input vec_t v);
    int req_seen = 0;
    int gnt_cyc  = -1;
    int nstall   = 0;
    int done_cyc = -1;
    string tag = $sformatf("v%0d", idx);
    req_i = 1'b1; we_i = v.we; funct3_i = v.f3; addr_i = v.addr;
    wr_data_i = v.wdata; bus_rdata_i = v.rdata;
    for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
      bus_gnt_i = 1'b0;
      bus_rvalid_i = 1'b0;
      if (bus_req_o) begin
        if (req_seen == 0) begin
          check({tag, " bus_addr"},  bus_addr_o,          v.e_addr);
          check({tag, " bus_be"},    {28'b0, bus_be_o},   {28'b0, v.e_be});
          check({tag, " bus_we"},    {31'b0, bus_we_o},   {31'b0, v.we});
          check({tag, " bus_wdata"}, bus_wdata_o,         v.e_wdata);
        end
        if (req_seen == v.gnt_dly) begin
          bus_gnt_i = 1'b1;
          gnt_cyc = cyc;
          if (v.rv_dly == 0) bus_rvalid_i = 1'b1;
        end
        req_seen++;
      end else if (gnt_cyc >= 0 && v.rv_dly > 0 && (cyc - gnt_cyc) == v.rv_dly) begin
        bus_rvalid_i = 1'b1;
      end
      #1;
      if (stall_o) nstall++;
      if (done_o) begin
        done_cyc = cyc;
        check({tag, " rd_data"}, rd_data_o,       v.e_rd);
        check({tag, " err"},     {31'b0, err_o},  {31'b0, v.e_err});
      end
      @(posedge clk); #1;
    end
    check({tag, " done_cycle"}, done_cyc, v.e_done);
    check({tag, " stall_cycles"}, nstall, v.e_done);
    check({tag, " req_cycles"}, req_seen, v.e_req);
    // req_i was still high during DONE; it must not have been re-accepted.
    req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    #1;
    check({tag, " idle bus_req"}, {31'b0, bus_req_o}, 32'h0);
    check({tag, " idle done"},    {31'b0, done_o},    32'h0);
    check({tag, " idle stall"},   {31'b0, stall_o},   32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(1'b0, 3'b010, 32'h100, 32'h12345678, 32'hDEADBEEF, 0, 2,
                      32'h100, 4'b1111, 32'h12345678, 32'hDEADBEEF, 1'b0, 4, 1));
    vecs.push_back(mk(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, 0, 0,
                      32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF00, 0, 0,
                      32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b0, 2, 1));
    vecs.push_back(mk(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 0,
                      32'h100, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2, 1,
                      32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 5, 3));
    vecs.push_back(mk(1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F00D, 1, 0,
                      32'h100, 4'b0011, 32'h0, 32'h0000F00D, 1'b0, 3, 2));
    vecs.push_back(mk(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'hFFFFFFFF, 0, 1,
                      32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 3, 1));
    vecs.push_back(mk(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 0,
                      32'h204, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0,
                      32'h100, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 0, -1,
                      32'h300, 4'b1111, 32'h0, 32'h0, 1'b1, 6, 1));
    vecs.push_back(mk(1'b0, 3'b011, 32'h400, 32'h0, 32'h11111111, 0, 0,
                      32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(1'b0, 3'b110, 32'h400, 32'h0, 32'h11111111, 0, 0,
                      32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h404, 32'h55, 32'h0, 0, 0,
                      32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0,
                      32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h101, 32'h0, 32'h00008000, 0, 0,
                      32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 0));
`else
    vecs.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0,
                      32'h100, 4'b1111, 32'h0, 32'h11223344, 1'b0, 2, 1));
    vecs.push_back(mk(1'b0, 3'b001, 32'h101, 32'h0, 32'h00008000, 0, 0,
                      32'h100, 4'b0011, 32'h0, 32'hFFFF8000, 1'b0, 2, 1));
`endif

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_i = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while an access is stuck in WAIT, then a normal access.
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h500; bus_rdata_i = 32'h55;
    @(posedge clk); #1;
    bus_gnt_i = 1'b1;
    #1;
    check("rstwait req", {31'b0, bus_req_o}, 32'h1);
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    #1;
    check("rstwait wait bus_req", {31'b0, bus_req_o}, 32'h0);
    check("rstwait wait stall",   {31'b0, stall_o},   32'h1);
    rst_i = 1'b0; req_i = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rstwait");
    rst_i = 1'b1;
    @(posedge clk); #1;
    run_vec(100, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
